// File: rtl/traffic_lights_cmd_gen.sv
// -----------------------------------------------------------------------------
// traffic_lights_cmd_gen
//
// Turns one high-level request (PROGRAM / OFF / BLINK / START) into a short
// sequence of command strobes for a traffic-light controller. Each command
// occupies one cycle. It is followed by CMD_GAP_CLK idle cycles. When the
// last gap ends, the block returns to IDLE and pulses done_o.
//
// Parameters
//   CMD_GAP_CLK      idle clocks after every command (legal 1..255)
//
// Optional feature
//   TL_CMD_GEN_ZERO_CHECK_EN  when defined, the block rejects a PROGRAM
//                             request that has any zero time field. The
//                             handshake still completes, error_o pulses and
//                             no command is issued.
//
// Ports
//   clk_i            clock, rising edge
//   arstn_i          asynchronous active-low reset
//   req_val_i        request valid
//   req_rdy_o        request ready (high only in IDLE)
//   req_mode_i       0 PROGRAM, 1 OFF, 2 BLINK, 3 START
//   req_green_ms_i   green phase time in ms (PROGRAM only)
//   req_red_ms_i     red phase time in ms (PROGRAM only)
//   req_yellow_ms_i  yellow phase time in ms (PROGRAM only)
//   cmd_val_o        command strobe
//   cmd_type_o       0 ON, 1 OFF, 2 YELLOW_BLINK, 3 SET_GREEN, 4 SET_RED,
//                    5 SET_YELLOW
//   cmd_data_o       command payload in ms
//   done_o           one-cycle pulse when a sequence completes
//   error_o          one-cycle pulse when a request is rejected
// -----------------------------------------------------------------------------
module traffic_lights_cmd_gen #(
  parameter int CMD_GAP_CLK = 2
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        req_val_i,
  output logic        req_rdy_o,
  input  logic [1:0]  req_mode_i,
  input  logic [15:0] req_green_ms_i,
  input  logic [15:0] req_red_ms_i,
  input  logic [15:0] req_yellow_ms_i,
  output logic        cmd_val_o,
  output logic [2:0]  cmd_type_o,
  output logic [15:0] cmd_data_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0] MODE_PROGRAM = 2'd0;
  localparam logic [1:0] MODE_OFF     = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_START   = 2'd3;

  // The counter is loaded with gap-1 and counts down to zero, so GAP lasts
  // exactly CMD_GAP_CLK cycles.
  localparam logic [7:0] GAP_LOAD = 8'(CMD_GAP_CLK - 1);

  state_t      state_r;
  logic [2:0]  idx_r;
  logic [7:0]  gap_cnt_r;
  logic [1:0]  mode_r;
  logic [15:0] green_r;
  logic [15:0] red_r;
  logic [15:0] yellow_r;
  logic        rdy_r;
  logic        cmd_val_r;
  logic [2:0]  cmd_type_r;
  logic [15:0] cmd_data_r;
  logic        done_r;
  logic        error_r;
  logic        reject_s;

  // Command type of sequence entry idx for a given mode.
  function automatic logic [2:0] seq_type(input logic [1:0] mode,
                                          input logic [2:0] idx);
    logic [2:0] t;
    case (mode)
      MODE_PROGRAM: begin
        case (idx)
          3'd0:    t = 3'd2;
          3'd1:    t = 3'd3;
          3'd2:    t = 3'd4;
          3'd3:    t = 3'd5;
          default: t = 3'd0;
        endcase
      end
      MODE_OFF:   t = 3'd1;
      MODE_BLINK: t = 3'd2;
      MODE_START: t = 3'd0;
      default:    t = 3'd0;
    endcase
    return t;
  endfunction

  // Payload of sequence entry idx. Only the SET_* entries of PROGRAM carry
  // a time value.
  function automatic logic [15:0] seq_data(input logic [1:0]  mode,
                                           input logic [2:0]  idx,
                                           input logic [15:0] g,
                                           input logic [15:0] r,
                                           input logic [15:0] y);
    logic [15:0] d;
    if (mode == MODE_PROGRAM) begin
      case (idx)
        3'd1:    d = g;
        3'd2:    d = r;
        3'd3:    d = y;
        default: d = 16'd0;
      endcase
    end else begin
      d = 16'd0;
    end
    return d;
  endfunction

  // Index of the final entry of a mode's sequence.
  function automatic logic [2:0] last_idx(input logic [1:0] mode);
    return (mode == MODE_PROGRAM) ? 3'd4 : 3'd0;
  endfunction

  // Decide whether an incoming request is rejected.
  always_comb begin
    reject_s = 1'b0;
`ifdef TL_CMD_GEN_ZERO_CHECK_EN
    if ((req_mode_i == MODE_PROGRAM) &&
        ((req_green_ms_i == 16'd0) || (req_red_ms_i == 16'd0) ||
         (req_yellow_ms_i == 16'd0))) begin
      reject_s = 1'b1;
    end else begin
      reject_s = 1'b0;
    end
`else
    reject_s = 1'b0;
`endif
  end

  // Main sequencer FSM with registered outputs.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_r    <= IDLE;
      idx_r      <= 3'd0;
      gap_cnt_r  <= 8'd0;
      mode_r     <= 2'd0;
      green_r    <= 16'd0;
      red_r      <= 16'd0;
      yellow_r   <= 16'd0;
      rdy_r      <= 1'b1;
      cmd_val_r  <= 1'b0;
      cmd_type_r <= 3'd0;
      cmd_data_r <= 16'd0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_val_i) begin
            mode_r   <= req_mode_i;
            green_r  <= req_green_ms_i;
            red_r    <= req_red_ms_i;
            yellow_r <= req_yellow_ms_i;
            idx_r    <= 3'd0;
            if (reject_s) begin
              error_r <= 1'b1;
            end else begin
              // The first command uses the live inputs because the
              // latched copies only become valid on this same edge.
              state_r    <= ISSUE;
              rdy_r      <= 1'b0;
              cmd_val_r  <= 1'b1;
              cmd_type_r <= seq_type(req_mode_i, 3'd0);
              cmd_data_r <= seq_data(req_mode_i, 3'd0, req_green_ms_i,
                                     req_red_ms_i, req_yellow_ms_i);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          cmd_val_r  <= 1'b0;
          cmd_type_r <= 3'd0;
          cmd_data_r <= 16'd0;
          gap_cnt_r  <= GAP_LOAD;
          state_r    <= GAP;
        end
        GAP: begin
          if (gap_cnt_r != 8'd0) begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
          end else if (idx_r == last_idx(mode_r)) begin
            state_r <= IDLE;
            rdy_r   <= 1'b1;
            done_r  <= 1'b1;
          end else begin
            idx_r      <= idx_r + 3'd1;
            state_r    <= ISSUE;
            cmd_val_r  <= 1'b1;
            cmd_type_r <= seq_type(mode_r, idx_r + 3'd1);
            cmd_data_r <= seq_data(mode_r, idx_r + 3'd1, green_r, red_r,
                                   yellow_r);
          end
        end
        default: begin
          state_r    <= IDLE;
          rdy_r      <= 1'b1;
          cmd_val_r  <= 1'b0;
          cmd_type_r <= 3'd0;
          cmd_data_r <= 16'd0;
        end
      endcase
    end
  end

  assign req_rdy_o  = rdy_r;
  assign cmd_val_o  = cmd_val_r;
  assign cmd_type_o = cmd_type_r;
  assign cmd_data_o = cmd_data_r;
  assign done_o     = done_r;
  assign error_o    = error_r;

endmodule

// File: tb/tb_traffic_lights_cmd_gen.sv
// -----------------------------------------------------------------------------
// tb_traffic_lights_cmd_gen
//
// Directed, table-driven bench for traffic_lights_cmd_gen with the default
// gap of 2 clocks. Each table record holds one request and its hand-written
// command sequence. A hand-written sequence covers reset in the middle of a
// PROGRAM request. Honours TL_CMD_GEN_ZERO_CHECK_EN for the zero-time entry.
// -----------------------------------------------------------------------------
module tb_traffic_lights_cmd_gen;

  logic        clk = 1'b0;
  logic        arstn_i;
  logic        req_val_i;
  logic        req_rdy_o;
  logic [1:0]  req_mode_i;
  logic [15:0] req_green_ms_i;
  logic [15:0] req_red_ms_i;
  logic [15:0] req_yellow_ms_i;
  logic        cmd_val_o;
  logic [2:0]  cmd_type_o;
  logic [15:0] cmd_data_o;
  logic        done_o;
  logic        error_o;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  traffic_lights_cmd_gen #(.CMD_GAP_CLK(2)) dut (
    .clk_i           (clk),
    .arstn_i         (arstn_i),
    .req_val_i       (req_val_i),
    .req_rdy_o       (req_rdy_o),
    .req_mode_i      (req_mode_i),
    .req_green_ms_i  (req_green_ms_i),
    .req_red_ms_i    (req_red_ms_i),
    .req_yellow_ms_i (req_yellow_ms_i),
    .cmd_val_o       (cmd_val_o),
    .cmd_type_o      (cmd_type_o),
    .cmd_data_o      (cmd_data_o),
    .done_o          (done_o),
    .error_o         (error_o)
  );

  // t[i]/d[i] is the expected type/data of the i-th command (index 0 is the
  // rightmost element of each concatenation).
  typedef struct packed {
    logic [1:0]       mode;
    logic [15:0]      g;
    logic [15:0]      r;
    logic [15:0]      y;
    logic [2:0]       n;
    logic [4:0][2:0]  t;
    logic [4:0][15:0] d;
    logic             err;
    logic             hold;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];
  int   first_cyc[NV];
  int   last_first_cyc;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge. Issues one request, then checks every cycle up to
  // and including the done cycle. It returns at that negedge, so the next
  // call is accepted back-to-back.
  task automatic run_req(input vec_t v, input string tag);
    int w;
    int last;
    int k;
    int idx;
    logic exp_val;
    w = 0;
    while (!req_rdy_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " rdy_before_req"}, {31'd0, req_rdy_o}, 32'd1);
    req_val_i       = 1'b1;
    req_mode_i      = v.mode;
    req_green_ms_i  = v.g;
    req_red_ms_i    = v.r;
    req_yellow_ms_i = v.y;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after acceptance. A held request must not be queued.
    req_val_i       = v.hold;
    req_mode_i      = 2'd0;
    req_green_ms_i  = 16'hffff;
    req_red_ms_i    = 16'hffff;
    req_yellow_ms_i = 16'hffff;
    last = v.err ? 4 : 3 * int'(v.n) + 1;
    last_first_cyc = -1;
    for (k = 1; k <= last; k++) begin
      if (k == 4) req_val_i = 1'b0;
      exp_val = !v.err && (k % 3 == 1) && (k <= 3 * int'(v.n) - 2);
      chk($sformatf("%s k%0d cmd_val", tag, k), {31'd0, cmd_val_o}, {31'd0, exp_val});
      if (exp_val) begin
        idx = (k - 1) / 3;
        if (k == 1) last_first_cyc = cyc;
        chk($sformatf("%s k%0d cmd_type", tag, k), {29'd0, cmd_type_o}, {29'd0, v.t[idx]});
        chk($sformatf("%s k%0d cmd_data", tag, k), {16'd0, cmd_data_o}, {16'd0, v.d[idx]});
      end else begin
        chk($sformatf("%s k%0d idle_type", tag, k), {29'd0, cmd_type_o}, 32'd0);
        chk($sformatf("%s k%0d idle_data", tag, k), {16'd0, cmd_data_o}, 32'd0);
      end
      chk($sformatf("%s k%0d done", tag, k), {31'd0, done_o},
          {31'd0, (!v.err && k == last)});
      chk($sformatf("%s k%0d error", tag, k), {31'd0, error_o},
          {31'd0, (v.err && k == 1)});
      chk($sformatf("%s k%0d rdy", tag, k), {31'd0, req_rdy_o},
          {31'd0, (v.err || k == last)});
      if (k < last) @(negedge clk);
    end
    req_val_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t prog;
    int   k;

    // PROGRAM 1000/2000/500 -> 2,3,4,5,0
    vecs[0] = '{mode:2'd0, g:16'd1000, r:16'd2000, y:16'd500, n:3'd5,
                t:{3'd0, 3'd5, 3'd4, 3'd3, 3'd2},
                d:{16'd0, 16'd500, 16'd2000, 16'd1000, 16'd0},
                err:1'b0, hold:1'b0};
    // OFF with req_val held high while busy
    vecs[1] = '{mode:2'd1, g:16'd0, r:16'd0, y:16'd0, n:3'd1,
                t:{3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, d:'0, err:1'b0, hold:1'b1};
    // BLINK, then START accepted in the BLINK done cycle
    vecs[2] = '{mode:2'd2, g:16'd11, r:16'd12, y:16'd13, n:3'd1,
                t:{3'd0, 3'd0, 3'd0, 3'd0, 3'd2}, d:'0, err:1'b0, hold:1'b0};
    vecs[3] = '{mode:2'd3, g:16'd21, r:16'd22, y:16'd23, n:3'd1,
                t:'0, d:'0, err:1'b0, hold:1'b0};
    // PROGRAM with red = 0
`ifdef TL_CMD_GEN_ZERO_CHECK_EN
    vecs[4] = '{mode:2'd0, g:16'd300, r:16'd0, y:16'd400, n:3'd0,
                t:'0, d:'0, err:1'b1, hold:1'b0};
`else
    vecs[4] = '{mode:2'd0, g:16'd300, r:16'd0, y:16'd400, n:3'd5,
                t:{3'd0, 3'd5, 3'd4, 3'd3, 3'd2},
                d:{16'd0, 16'd400, 16'd0, 16'd300, 16'd0},
                err:1'b0, hold:1'b0};
`endif
    // PROGRAM with odd values, back-to-back after the previous entry
    vecs[5] = '{mode:2'd0, g:16'h1234, r:16'hbeef, y:16'd7, n:3'd5,
                t:{3'd0, 3'd5, 3'd4, 3'd3, 3'd2},
                d:{16'd0, 16'd7, 16'hbeef, 16'h1234, 16'd0},
                err:1'b0, hold:1'b0};

    arstn_i         = 1'b0;
    req_val_i       = 1'b0;
    req_mode_i      = 2'd0;
    req_green_ms_i  = 16'd0;
    req_red_ms_i    = 16'd0;
    req_yellow_ms_i = 16'd0;

    // Outputs while in reset
    @(negedge clk);
    chk("reset rdy",      {31'd0, req_rdy_o}, 32'd1);
    chk("reset cmd_val",  {31'd0, cmd_val_o}, 32'd0);
    chk("reset cmd_type", {29'd0, cmd_type_o}, 32'd0);
    chk("reset cmd_data", {16'd0, cmd_data_o}, 32'd0);
    chk("reset done",     {31'd0, done_o}, 32'd0);
    chk("reset error",    {31'd0, error_o}, 32'd0);
    arstn_i = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_req(vecs[i], $sformatf("vec%0d", i));
      first_cyc[i] = last_first_cyc;
    end
    // BLINK cmd to START cmd: gap+1 plus one accept cycle
    chk("b2b spacing", first_cyc[3] - first_cyc[2], 32'd4);

    // Reset during the third command of a PROGRAM sequence
    prog = vecs[0];
    @(negedge clk);
    req_val_i       = 1'b1;
    req_mode_i      = prog.mode;
    req_green_ms_i  = prog.g;
    req_red_ms_i    = prog.r;
    req_yellow_ms_i = prog.y;
    @(posedge clk);
    for (k = 1; k <= 7; k++) begin
      @(negedge clk);
      req_val_i = 1'b0;
    end
    chk("rst third cmd val",  {31'd0, cmd_val_o}, 32'd1);
    chk("rst third cmd type", {29'd0, cmd_type_o}, 32'd4);
    #1 arstn_i = 1'b0;
    #1;
    chk("rst async cmd_val", {31'd0, cmd_val_o}, 32'd0);
    chk("rst async rdy",     {31'd0, req_rdy_o}, 32'd1);
    chk("rst async type",    {29'd0, cmd_type_o}, 32'd0);
    chk("rst async data",    {16'd0, cmd_data_o}, 32'd0);
    @(negedge clk);
    arstn_i = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("post rst c%0d cmd_val", k), {31'd0, cmd_val_o}, 32'd0);
      chk($sformatf("post rst c%0d done", k),    {31'd0, done_o}, 32'd0);
      chk($sformatf("post rst c%0d rdy", k),     {31'd0, req_rdy_o}, 32'd1);
    end
    run_req(prog, "after_rst");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
